// File: rtl/ai_cmd_rx.sv
// ai_cmd_rx: 8N1 UART command receiver for AI power requests.
// Ports: clk, rst_n, rx in; llm_kw, ai_valid, frame_err, frame_cnt out.
module ai_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int GAP_CYCLES   = 20000,
  parameter int STALE_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] llm_kw,
  output logic        ai_valid,
  output logic        frame_err,
  output logic [7:0]  frame_cnt
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int SW = $clog2(STALE_CYCLES + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_CYCLES - 1);
  localparam logic [SW-1:0] STL_END  = SW'(STALE_CYCLES - 1);
  localparam logic [SW-1:0] STL_SAT  = SW'(STALE_CYCLES);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  typedef enum logic [1:0] {
    P_HUNT, P_HI, P_LO, P_CHK
  } p_st_t;

  logic          rx_m, rx_s, rx_d;
  logic          fall;

  rx_st_t        rs, rs_nx;
  logic [CW-1:0] bcnt, bcnt_nx;
  logic [2:0]    bidx, bidx_nx;
  logic [7:0]    shreg, sh_nx;
  logic          byte_rdy, stop_err;

  p_st_t         ps, ps_nx;
  logic [7:0]    hi_b, hi_nx;
  logic [7:0]    lo_b, lo_nx;
  logic [GW-1:0] gap, gap_nx;
  logic          accept, chk_bad, gap_to;

  logic [SW-1:0] stale;
  logic          stale_hit;

  // rx_d is one more stage so a falling edge is seen on synced data only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs    <= R_IDLE;
      bcnt  <= '0;
      bidx  <= '0;
      shreg <= '0;
    end else begin
      rs    <= rs_nx;
      bcnt  <= bcnt_nx;
      bidx  <= bidx_nx;
      shreg <= sh_nx;
    end
  end

  always_comb begin
    rs_nx    = rs;
    bcnt_nx  = bcnt + 1'b1;
    bidx_nx  = bidx;
    sh_nx    = shreg;
    byte_rdy = 1'b0;
    stop_err = 1'b0;
    unique case (rs)
      R_IDLE: begin
        bcnt_nx = '0;
        if (fall) rs_nx = R_START;
      end
      R_START: begin
        if (bcnt == HALF_END) begin
          bcnt_nx = '0;
          bidx_nx = '0;
          rs_nx   = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (bcnt == BIT_END) begin
          bcnt_nx = '0;
          sh_nx   = {rx_s, shreg[7:1]};
          bidx_nx = bidx + 3'd1;
          if (bidx == 3'd7) rs_nx = R_STOP;
        end
      end
      R_STOP: begin
        if (bcnt == BIT_END) begin
          bcnt_nx  = '0;
          rs_nx    = R_IDLE;
          byte_rdy = rx_s;
          stop_err = ~rx_s;
        end
      end
      default: rs_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps   <= P_HUNT;
      hi_b <= '0;
      lo_b <= '0;
      gap  <= '0;
    end else begin
      ps   <= ps_nx;
      hi_b <= hi_nx;
      lo_b <= lo_nx;
      gap  <= gap_nx;
    end
  end

  // A received byte takes priority over a gap expiry on the same cycle
  always_comb begin
    ps_nx   = ps;
    hi_nx   = hi_b;
    lo_nx   = lo_b;
    accept  = 1'b0;
    chk_bad = 1'b0;
    gap_to  = 1'b0;
    gap_nx  = (ps == P_HUNT || byte_rdy) ? '0 : gap + 1'b1;
    if (byte_rdy) begin
      unique case (ps)
        P_HUNT: if (shreg == 8'hA5) ps_nx = P_HI;
        P_HI: begin
          hi_nx = shreg;
          ps_nx = P_LO;
        end
        P_LO: begin
          lo_nx = shreg;
          ps_nx = P_CHK;
        end
        P_CHK: begin
          ps_nx = P_HUNT;
          if (shreg == (hi_b ^ lo_b)) accept  = 1'b1;
          else                        chk_bad = 1'b1;
        end
        default: ps_nx = P_HUNT;
      endcase
    end else if (stop_err) begin
      ps_nx = P_HUNT;
    end else if (ps != P_HUNT && gap == GAP_END) begin
      gap_to = 1'b1;
      ps_nx  = P_HUNT;
    end
  end

  assign stale_hit = (stale == STL_END);

  // Accepted frame beats watchdog expiry; watchdog saturates once expired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      llm_kw    <= '0;
      ai_valid  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      stale     <= '0;
    end else begin
      frame_err <= stop_err | chk_bad | gap_to;
      if (accept) begin
        llm_kw    <= {hi_b, lo_b};
        ai_valid  <= 1'b1;
        frame_cnt <= frame_cnt + 8'd1;
        stale     <= '0;
      end else begin
        if (stale_hit) begin
          llm_kw   <= '0;
          ai_valid <= 1'b0;
        end
        if (stale != STL_SAT) stale <= stale + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ai_cmd_rx.sv
// tb_ai_cmd_rx: directed bench for ai_cmd_rx.
// Drives UART frames on rx, checks outputs on negedges.
module tb_ai_cmd_rx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] llm_kw;
  logic        ai_valid;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int e0;

  ai_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .GAP_CYCLES(200),
    .STALE_CYCLES(1000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .llm_kw(llm_kw),
    .ai_valid(ai_valid),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) err_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] c);
    send_byte(a, 1'b1);
    send_byte(h, 1'b1);
    send_byte(l, 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_kw", llm_kw, 0);
    chk("rst_valid", ai_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_cnt", frame_cnt, 0);

    // basic frame with exact output latency
    e0 = err_cnt;
    send_frame(8'hA5, 8'h01, 8'hF4, 8'hF5);
    chk("basic_pre_valid", ai_valid, 0);
    @(negedge clk);
    chk("basic_valid", ai_valid, 1);
    chk("basic_kw", llm_kw, 16'h01F4);
    chk("basic_cnt", frame_cnt, 1);
    chk("basic_noerr", err_cnt - e0, 0);

    // bad checksum from reset
    do_reset();
    e0 = err_cnt;
    send_frame(8'hA5, 8'h00, 8'h64, 8'h65);
    repeat (3) @(negedge clk);
    chk("badchk_kw", llm_kw, 0);
    chk("badchk_valid", ai_valid, 0);
    chk("badchk_cnt", frame_cnt, 0);
    chk("badchk_err", err_cnt - e0, 1);

    // junk bytes then a good frame
    e0 = err_cnt;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h00, 1'b1);
    send_frame(8'hA5, 8'h12, 8'h34, 8'h26);
    repeat (3) @(negedge clk);
    chk("noise_err", err_cnt - e0, 0);
    chk("noise_kw", llm_kw, 16'h1234);
    chk("noise_cnt", frame_cnt, 1);

    // watchdog expires exactly 1000 cycles after acceptance
    send_frame(8'hA5, 8'h01, 8'hF4, 8'hF5);
    @(negedge clk);
    chk("wd_acc_kw", llm_kw, 16'h01F4);
    repeat (999) @(negedge clk);
    chk("wd_hold_valid", ai_valid, 1);
    @(negedge clk);
    chk("wd_exp_valid", ai_valid, 0);
    chk("wd_exp_kw", llm_kw, 0);
    repeat (50) @(negedge clk);
    send_frame(8'hA5, 8'h00, 8'h0A, 8'h0A);
    repeat (3) @(negedge clk);
    chk("wd_rest_valid", ai_valid, 1);
    chk("wd_rest_kw", llm_kw, 16'd10);
    chk("wd_rest_cnt", frame_cnt, 3);

    // stop bit low on HI byte forces parser back to hunt
    e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_err", err_cnt - e0, 1);
    send_frame(8'hA5, 8'h02, 8'h03, 8'h01);
    repeat (3) @(negedge clk);
    chk("ferr_kw", llm_kw, 16'h0203);
    chk("ferr_err2", err_cnt - e0, 1);

    // inter-byte gap timeout
    e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (250) @(negedge clk);
    chk("gap_err", err_cnt - e0, 1);
    chk("gap_kw_kept", llm_kw, 16'h0203);
    send_frame(8'hA5, 8'h03, 8'hE8, 8'hEB);
    repeat (3) @(negedge clk);
    chk("gap_kw", llm_kw, 16'h03E8);
    chk("gap_err2", err_cnt - e0, 1);
    chk("gap_cnt", frame_cnt, 5);

    // reset during LO byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    chk("pre_rst_kw", llm_kw, 16'h03E8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_kw", llm_kw, 0);
    chk("mid_rst_valid", ai_valid, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'hA5, 8'h00, 8'h0A, 8'h0A);
    repeat (3) @(negedge clk);
    chk("post_rst_kw", llm_kw, 16'd10);
    chk("post_rst_cnt", frame_cnt, 1);

    // 256 back-to-back frames wrap the counter
    do_reset();
    e0 = err_cnt;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] h;
      h = i[7:0];
      send_frame(8'hA5, h, ~h, 8'hFF);
      if (i == 254) begin
        @(negedge clk);
        chk("wrap_255", frame_cnt, 255);
      end
    end
    repeat (3) @(negedge clk);
    chk("wrap_0", frame_cnt, 0);
    chk("wrap_kw", llm_kw, 16'hFF00);
    chk("wrap_valid", ai_valid, 1);
    chk("wrap_err", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ai_cmd_rx.md
# ai_cmd_rx

Serial command front-end for the safety core. It receives AI power requests as 8N1 UART byte frames, validates them, and presents a registered `llm_kw` request with an `ai_valid` qualifier. It drives the gate's `llm_requested_kw` and `ai_data_valid` inputs directly. A staleness watchdog withdraws `ai_valid` and zeroes the request when the AI link goes quiet, so the gate always falls back to its safe path.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); minimum 4.
- `GAP_CYCLES`, default 20000: maximum idle cycles allowed between bytes inside one frame.
- `STALE_CYCLES`, default 5000000: cycles without a good frame before the request is withdrawn.
- `clk`  in  1  system clock; sole clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART line, asynchronous, idles high.
- `llm_kw`  out  16  last accepted request in kW; goes to the gate's `llm_requested_kw`.
- `ai_valid`  out  1  request is fresh and checksum-valid; goes to the gate's `ai_data_valid`.
- `frame_err`  out  1  one-cycle pulse on a framing, checksum or gap error.
- `frame_cnt`  out  8  count of accepted frames; wraps from 255 to 0.

## Operation
- **Input sync:** `rx` passes through a 2-FF synchronizer. Sync flops reset to 1.
- **Byte receiver states:** IDLE, START, DATA, STOP.
  - IDLE→START on a synchronized falling edge.
  - START re-checks the line at CLKS_PER_BIT/2. If high, it is a glitch: return to IDLE with no error.
  - DATA samples 8 bits at CLKS_PER_BIT intervals, LSB first.
  - STOP samples the stop bit. If it is 1, emit a one-cycle `byte_rdy`. If it is 0, pulse `frame_err` and reset the parser to HUNT.
  - Then return to IDLE.
- **Frame format:** 0xA5, HI, LO, CHK, where CHK = HI ^ LO.
- **Parser states:** HUNT, HI, LO, CHK.
  - HUNT: bytes other than 0xA5 are dropped silently. 0xA5 moves to HI.
  - HI and LO latch their bytes, then advance.
  - CHK match: `llm_kw` <= {HI, LO}, `ai_valid` <= 1, `frame_cnt` += 1, watchdog cleared. Return to HUNT.
  - CHK mismatch: pulse `frame_err`, outputs unchanged, return to HUNT.
  - A 0xA5 received in HI, LO or CHK is treated as data, not as a resync.
- **Gap timer:** runs only in the HI, LO and CHK states and restarts on every `byte_rdy`. When it reaches GAP_CYCLES: pulse `frame_err`, go to HUNT, outputs unchanged.
- **Staleness watchdog:** counts every cycle and is cleared only on an accepted frame. When it reaches STALE_CYCLES: `ai_valid` <= 0 and `llm_kw` <= 0. The counter then saturates and holds there until the next good frame.
- **Simultaneous events:** an accepted frame on the same cycle the watchdog expires wins. The frame is loaded and the watchdog is cleared.
- **Width rules:** no arithmetic on `llm_kw`; it is passed through unsaturated. The gate enforces all limits.

## Timing
- **Reset values (asynchronous, on `rst_n` low):** `llm_kw`=0, `ai_valid`=0, `frame_err`=0, `frame_cnt`=0. Receiver goes to IDLE, parser to HUNT, all counters to 0.
- **Reset mid-frame:** the partial frame is discarded. After release, reception resumes from the next falling edge on `rx`.
- **Output latency:** `llm_kw` and `ai_valid` update on the edge following the stop-bit sample cycle of the CHK byte.
- **`frame_err` timing:** a one-cycle pulse asserted on that same edge.
- **Registered outputs:** all outputs are registered, with no combinational path from `rx`.
- **Update behaviour:** `llm_kw` changes only on acceptance or on watchdog expiry, never mid-frame.
- **Back-to-back frames:** accepted with no idle gap required. A new start edge may begin during the cycle after STOP.

## Test plan
Run with CLKS_PER_BIT=4, GAP_CYCLES=200, STALE_CYCLES=1000.
- **Basic frame:** after reset, send A5 01 F4 F5 → `llm_kw`=0x01F4 (500) and `ai_valid`=1 one cycle after the CHK stop sample; `frame_cnt`=1; no `frame_err`.
- **Bad checksum:** send A5 00 64 65 → `llm_kw`=0, `ai_valid`=0, `frame_cnt`=0, plus exactly one `frame_err` pulse.
- **Noise then frame:** send junk 3C 00, then A5 12 34 26 → junk is ignored without error; `llm_kw`=0x1234.
- **Watchdog expiry:** send A5 01 F4 F5, then keep `rx` high → exactly 1000 cycles after acceptance `ai_valid`=0 and `llm_kw`=0. A following A5 00 0A 0A restores `ai_valid`=1, `llm_kw`=10.
- **Framing error and gap timeout:** a stop bit forced low on the HI byte → `frame_err` pulse and parser back to HUNT. Separately, send A5 01 then idle 250 cycles → `frame_err` pulse, and a subsequent good frame is accepted.
- **Reset mid-frame and counter wrap:** assert `rst_n` low during the LO byte → all outputs 0 immediately; the next full frame is accepted. Sending 256 good frames → `frame_cnt` wraps to 0.
